// File: rtl/shift_pkg.sv
// Shared shifter definitions: operation encoding, default payload layout and a width helper.
// The ALU imports this package as well, so the encodings here are fixed.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_ROL = 2'b10,
        SHIFT_SRA = 2'b11
    } shift_op_t;

    function automatic int log2ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int SHIFT_N     = 32;
    localparam int SHIFT_TAG_W = 4;
    localparam int SHIFT_L     = log2ceil(SHIFT_N);

    // Stage payload for the default datapath width.
    typedef struct packed {
        logic [SHIFT_N-1:0]     data;
        shift_op_t              op;
        logic [SHIFT_L-1:0]     shamt;
        logic                   sign;
        logic [SHIFT_TAG_W-1:0] tag;
    } shift_payload_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts by 2^K and registers
// the result together with the payload that travels alongside it.
module shift_stage
    import shift_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4,
    parameter int K     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    input  logic                    in_valid,
    input  logic [N-1:0]            in_data,
    input  shift_op_t               in_op,
    input  logic [log2ceil(N)-1:0]  in_shamt,
    input  logic                    in_sign,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    output logic [N-1:0]            out_data,
    output shift_op_t               out_op,
    output logic [log2ceil(N)-1:0]  out_shamt,
    output logic                    out_sign,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int L = log2ceil(N);
    localparam int S = 1 << K;
    localparam logic [N-1:0] ONES = '1;

    typedef struct packed {
        logic [N-1:0]     data;
        shift_op_t        op;
        logic [L-1:0]     shamt;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t     pl_q;
    logic         valid_q;
    logic [N-1:0] shifted;

    // The SRA fill comes from the carried sign of the original operand, not the current MSB.
    always_comb begin
        shifted = in_data;
        if (in_shamt[K]) begin
            unique case (in_op)
                SHIFT_SLL: shifted = in_data << S;
                SHIFT_SRL: shifted = in_data >> S;
                SHIFT_ROL: shifted = (in_data << S) | (in_data >> (N - S));
                SHIFT_SRA: shifted = (in_data >> S) | (in_sign ? ~(ONES >> S) : '0);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else if (adv) begin
            valid_q    <= in_valid;
            pl_q.data  <= shifted;
            pl_q.op    <= in_op;
            pl_q.shamt <= in_shamt;
            pl_q.sign  <= in_sign;
            pl_q.tag   <= in_tag;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = pl_q.data;
    assign out_op    = pl_q.op;
    assign out_shamt = pl_q.shamt;
    assign out_sign  = pl_q.sign;
    assign out_tag   = pl_q.tag;

endmodule

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter (SLL/SRL/ROL/SRA) built from log2(N) registered stages.
// Handshake: a transfer happens on any edge where valid && ready; the whole pipe advances together.
module shifter_pipelined
    import shift_pkg::*;
#(
    parameter int N       = 32,
    parameter int TAG_W   = 4,
    localparam int L      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [L-1:0]     in_shamt,
    input  shift_op_t        in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             v_c  [L+1];
    logic [N-1:0]     d_c  [L+1];
    shift_op_t        op_c [L+1];
    logic [L-1:0]     sh_c [L+1];
    logic             sg_c [L+1];
    logic [TAG_W-1:0] tg_c [L+1];
    logic             adv;

    // Stalls are global: bubbles keep their slot rather than being squeezed out.
    assign adv      = !v_c[L] || out_ready;
    assign in_ready = adv;

    assign v_c[0]  = in_valid;
    assign d_c[0]  = in_data;
    assign op_c[0] = in_op;
    assign sh_c[0] = in_shamt;
    assign sg_c[0] = in_data[N-1];
    assign tg_c[0] = in_tag;

    for (genvar k = 0; k < L; k++) begin : g_stage
        shift_stage #(
            .N     (N),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .in_valid  (v_c[k]),
            .in_data   (d_c[k]),
            .in_op     (op_c[k]),
            .in_shamt  (sh_c[k]),
            .in_sign   (sg_c[k]),
            .in_tag    (tg_c[k]),
            .out_valid (v_c[k+1]),
            .out_data  (d_c[k+1]),
            .out_op    (op_c[k+1]),
            .out_shamt (sh_c[k+1]),
            .out_sign  (sg_c[k+1]),
            .out_tag   (tg_c[k+1])
        );
    end

    assign out_valid = v_c[L];
    assign out_data  = d_c[L];
    assign out_tag   = tg_c[L];

endmodule

// File: tb/tb_shifter_pipelined.sv
// Scoreboard bench for shifter_pipelined: directed vectors, streams with stall, reset flush.
module tb_shifter_pipelined;
    import shift_pkg::*;

    localparam int N     = 32;
    localparam int TAG_W = 4;
    localparam int L     = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [L-1:0]     in_shamt;
    shift_op_t        in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    shifter_pipelined #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [TAG_W+N-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;
    int stream_base = 0;
    int stream_first = 0;
    int last_pop = 0;
    int issue_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return (s == 0) ? d : ((d << s) | (d >> (N - s)));
            default: return $unsigned($signed(d) >>> s);
        endcase
    endfunction

    // driver tasks
    task automatic send(input logic [N-1:0] d, input int s, input logic [1:0] op,
                        input logic [TAG_W-1:0] tag, input logic [N-1:0] exp);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = L'(s);
        in_op    = shift_op_t'(op);
        in_tag   = tag;
        for (int w = 0; w < 60 && !acc; w++) begin
            #3;
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back({tag, exp});
                issue_cyc = cyc;
            end
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        #4;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // monitor: pops expected results and checks stability while stalled
    logic             stall_seen = 1'b0;
    logic [N-1:0]     hold_d;
    logic [TAG_W-1:0] hold_t;

    initial begin
        logic [TAG_W+N-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                stall_seen = 1'b0;
                continue;
            end
            if (stall_seen && out_valid) begin
                chk("hold_data", 64'(out_data), 64'(hold_d));
                chk("hold_tag", 64'(out_tag), 64'(hold_t));
            end
            stall_seen = 1'b0;
            if (out_valid && !out_ready) begin
                stall_seen = 1'b1;
                hold_d = out_data;
                hold_t = out_tag;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got tag %0d data %h expected none", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e[N-1:0]));
                    chk("out_tag", 64'(out_tag), 64'(e[TAG_W+N-1:N]));
                end
                if (pop_cnt == stream_base) stream_first = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
    end

    // main sequence
    initial begin
        logic [N-1:0] d;
        int s;
        logic [1:0] op;
        bit seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SHIFT_SLL;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);

        // first result latency on an idle pipe
        send(32'h0000_0001, 31, 2'b00, 4'd1, 32'h8000_0000);
        idle();
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            #3;
            seen = out_valid;
        end
        chk("latency", 64'(cyc - issue_cyc), 64'd5);
        drain();

        // directed vectors
        send(32'h8000_0000, 4,  2'b11, 4'd2,  32'hF800_0000);
        send(32'h8000_0000, 4,  2'b01, 4'd3,  32'h0800_0000);
        send(32'h8000_0001, 1,  2'b10, 4'd4,  32'h0000_0003);
        send(32'hA5A5_1234, 0,  2'b00, 4'd5,  32'hA5A5_1234);
        send(32'hA5A5_1234, 0,  2'b01, 4'd6,  32'hA5A5_1234);
        send(32'hA5A5_1234, 0,  2'b10, 4'd7,  32'hA5A5_1234);
        send(32'hA5A5_1234, 0,  2'b11, 4'd8,  32'hA5A5_1234);
        send(32'h8000_0000, 31, 2'b11, 4'd9,  32'hFFFF_FFFF);
        send(32'h8765_4321, 31, 2'b11, 4'd10, 32'hFFFF_FFFF);
        send(32'h1234_5678, 4,  2'b10, 4'd11, 32'h2345_6781);
        send(32'hFFFF_FFFF, 31, 2'b01, 4'd12, 32'h0000_0001);
        send(32'h7FFF_FFFF, 30, 2'b11, 4'd13, 32'h0000_0001);
        send(32'h8000_0000, 31, 2'b10, 4'd14, 32'h4000_0000);
        send(32'hF0F0_F0F0, 7,  2'b00, 4'd15, 32'h7878_7800);
        idle();
        drain();

        // back-to-back stream, out_ready held high
        stream_base = pop_cnt;
        for (int i = 0; i < 16; i++) begin
            d  = $urandom;
            s  = $urandom_range(0, N - 1);
            op = 2'($urandom_range(0, 3));
            send(d, s, op, 4'(i), model(d, s, op));
        end
        idle();
        drain();
        chk("throughput_span", 64'(last_pop - stream_first), 64'd15);

        // stream with a 7-cycle output stall in the middle
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    d  = $urandom;
                    s  = $urandom_range(0, N - 1);
                    op = 2'($urandom_range(0, 3));
                    send(d, s, op, 4'(15 - i), model(d, s, op));
                end
                idle();
            end
            begin
                repeat (8) @(negedge clk);
                out_ready = 1'b0;
                repeat (7) begin
                    #3;
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three operations in flight, head stalled at the output
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0000_00FF, 3, 2'b00, 4'd1, 32'h0000_07F8);
        send(32'h0000_00FF, 2, 2'b01, 4'd2, 32'h0000_003F);
        send(32'h8000_00FF, 1, 2'b11, 4'd3, 32'hC000_007F);
        idle();
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            #3;
            seen = out_valid;
        end
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("reset_drops_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 12; w++) begin
            #3;
            chk("post_reset_no_stale", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
